// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction fetch front end of the 9-bit CPU.
// Ports: clk/reset; imem_addr/imem_req/imem_rdata/imem_valid to instruction
// memory; stall and decoder feedback (branch, takeit, direct_flag,
// branch_target, branch_offset, halt); instruction/instr_valid/pc_out to the
// decoder; halted and sticky fetch_err status.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count and redirect_count.
module instr_fetch_unit #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int OFF_W    = 5,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PC_W-1:0]  imem_addr,
    output logic             imem_req,
    input  logic [8:0]       imem_rdata,
    input  logic             imem_valid,
    input  logic             stall,
    input  logic             branch,
    input  logic             takeit,
    input  logic             direct_flag,
    input  logic [PC_W-1:0]  branch_target,
    input  logic [OFF_W-1:0] branch_offset,
    input  logic             halt,
    output logic [8:0]       instruction,
    output logic             instr_valid,
    output logic [PC_W-1:0]  pc_out,
    output logic             halted,
    output logic             fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]      fetch_count,
    output logic [15:0]      redirect_count
`endif
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [CNT_W-1:0]  wait_cnt;

    logic              accept;
    logic              taken;
    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   seq_pc;
    logic [PC_W-1:0]   next_pc;

    assign accept  = ~stall;
    assign taken   = branch & takeit;
    assign off_ext = {{(PC_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
    // Successor is relative to the presented instruction, wrapping mod 2^PC_W.
    assign seq_pc  = pc_out + PC_W'(1);
    assign next_pc = !taken     ? seq_pc :
                     direct_flag ? branch_target :
                                   seq_pc + off_ext;

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= PC_W'(RESET_PC);
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            instruction <= 9'h000;
            instr_valid <= 1'b0;
            pc_out      <= PC_W'(RESET_PC);
            halted      <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_valid) begin
                        state       <= S_HOLD;
                        instruction <= imem_rdata;
                        pc_out      <= pc;
                        wait_cnt    <= '0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end else if (TIMEOUT != 0 && wait_cnt == LAST_WAIT) begin
                        state     <= S_FAULT;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        halted    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state    <= S_REQ;
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (state == S_REQ && imem_valid && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            // A halt takes priority, so a halting branch never redirects.
            if (state == S_HOLD && accept && !halt && taken &&
                redirect_count != 16'hFFFF)
                redirect_count <= redirect_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed bench for instr_fetch_unit
// with a transaction-level reference model and per-cycle output compare.
module tb_instr_fetch_unit;

    localparam int PW  = 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] imem_addr;
    logic          imem_req;
    logic [8:0]    imem_rdata = '0;
    logic          imem_valid = 1'b0;
    logic          stall = 1'b1;
    logic          branch = 1'b0;
    logic          takeit = 1'b0;
    logic          direct_flag = 1'b0;
    logic [PW-1:0] branch_target = '0;
    logic [4:0]    branch_offset = '0;
    logic          halt = 1'b0;
    logic [8:0]    instruction;
    logic          instr_valid;
    logic [PW-1:0] pc_out;
    logic          halted;
    logic          fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]   fetch_count;
    logic [15:0]   redirect_count;
`endif

    instr_fetch_unit #(
        .PC_W(PW), .RESET_PC(0), .OFF_W(5), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .stall(stall), .branch(branch), .takeit(takeit),
        .direct_flag(direct_flag), .branch_target(branch_target),
        .branch_offset(branch_offset), .halt(halt),
        .instruction(instruction), .instr_valid(instr_valid),
        .pc_out(pc_out), .halted(halted), .fetch_err(fetch_err)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h expected=%0h t=%0t",
                         nm, act, exp, $time);
        end
    endtask

    // Reference model: what the fetcher is doing, tracked per clock.
    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_HOLD  = 2;
    localparam int M_HALT  = 3;
    localparam int M_FAULT = 4;

    int       m_mode;
    int       m_wait;
    int       m_pc;
    int       m_pcout;
    int       m_instr;
    int       m_fc;
    int       m_rc;
    bit       m_ok = 0;

    always @(posedge clk) begin
        int off;
        int nxt;
        if (reset) begin
            m_mode = M_IDLE; m_wait = 0; m_pc = 0; m_pcout = 0;
            m_instr = 0; m_fc = 0; m_rc = 0; m_ok = 1;
        end else if (m_ok) begin
            if (m_mode == M_IDLE) begin
                m_mode = M_REQ;
            end else if (m_mode == M_REQ) begin
                if (imem_valid) begin
                    m_instr = int'(imem_rdata);
                    m_pcout = m_pc;
                    m_wait  = 0;
                    m_mode  = M_HOLD;
                    if (m_fc < 65535) m_fc++;
                end else begin
                    m_wait++;
                    if (TMO != 0 && m_wait >= TMO) m_mode = M_FAULT;
                end
            end else if (m_mode == M_HOLD && !stall) begin
                if (halt) begin
                    m_mode = M_HALT;
                end else begin
                    off = $signed(branch_offset);
                    if (branch && takeit) begin
                        if (m_rc < 65535) m_rc++;
                        nxt = direct_flag ? int'(branch_target)
                                          : m_pcout + 1 + off;
                    end else begin
                        nxt = m_pcout + 1;
                    end
                    m_pc   = nxt & 255;
                    m_mode = M_REQ;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("imem_req", 32'(imem_req), 32'(m_mode == M_REQ));
            chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("instr_valid", 32'(instr_valid), 32'(m_mode == M_HOLD));
            chk("instruction", 32'(instruction), 32'(m_instr));
            chk("pc_out", 32'(pc_out), 32'(m_pcout));
            chk("halted", 32'(halted),
                32'(m_mode == M_HALT || m_mode == M_FAULT));
            chk("fetch_err", 32'(fetch_err), 32'(m_mode == M_FAULT));
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", 32'(fetch_count), 32'(m_fc));
            chk("redirect_count", 32'(redirect_count), 32'(m_rc));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_valid = 1'b0;
        stall = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (imem_req) return;
            tick();
        end
        chk("wait_req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic serve(logic [8:0] d);
        wait_req();
        imem_valid = 1'b1;
        imem_rdata = d;
        tick();
        imem_valid = 1'b0;
    endtask

    task automatic accept(logic br, logic tk, logic dr,
                          logic [7:0] tg, logic [4:0] of, logic hl);
        stall = 1'b0;
        branch = br; takeit = tk; direct_flag = dr;
        branch_target = tg; branch_offset = of; halt = hl;
        tick();
        stall = 1'b1;
        branch = 1'b0; takeit = 1'b0; direct_flag = 1'b0; halt = 1'b0;
    endtask

    initial begin
        int hcnt;
        // Reset values and first-request latency.
        tick(); tick();
        reset = 1'b0;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_err", 32'(fetch_err) | 32'(halted), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);

        // Sequential fetch.
        for (int i = 0; i < 3; i++) begin
            wait_req();
            chk("seq_addr", 32'(imem_addr), 32'(i));
            serve(9'(9'h040 + i));
            chk("seq_instr", 32'(instruction), 32'(9'h040 + i));
            chk("seq_pcout", 32'(pc_out), 32'(i));
            accept(0, 0, 0, 0, 0, 0);
        end

        // Stall hold at pc 5.
        serve(9'h000);
        accept(1, 1, 1, 8'd5, 0, 0);
        wait_req();
        chk("jmp5_addr", 32'(imem_addr), 32'd5);
        serve(9'h1A3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", 32'(instruction), 32'h1A3);
            chk("stall_pcout", 32'(pc_out), 32'd5);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        accept(0, 0, 0, 0, 0, 0);
        chk("after_stall", 32'(imem_addr), 32'd6);

        // Branches and wrap.
        serve(9'h011);
        accept(1, 1, 1, 8'd10, 0, 0);
        serve(9'h012);
        chk("pc10", 32'(pc_out), 32'd10);
        accept(1, 1, 0, 8'd99, 5'b11101, 0);
        chk("rel_addr", 32'(imem_addr), 32'd8);
        serve(9'h013);
        accept(1, 1, 1, 8'd200, 5'b00111, 0);
        chk("abs_addr", 32'(imem_addr), 32'd200);
        serve(9'h014);
        accept(1, 0, 1, 8'd33, 0, 0);
        chk("not_taken", 32'(imem_addr), 32'd201);
        serve(9'h015);
        accept(1, 1, 1, 8'd255, 0, 0);
        serve(9'h016);
        accept(0, 0, 0, 0, 0, 0);
        chk("wrap_addr", 32'(imem_addr), 32'd0);

        // Halt wins over a taken branch.
        serve(9'h1FF);
        accept(1, 1, 1, 8'd50, 0, 1);
        chk("halted", 32'(halted), 32'd1);
        for (int i = 0; i < 5; i++) begin
            imem_valid = 1'b1;
            tick();
            chk("halt_req", 32'(imem_req), 32'd0);
        end
        imem_valid = 1'b0;

        // Timeout.
        do_reset();
        wait_req();
        tick(); tick(); tick();
        chk("tmo_early", 32'(fetch_err), 32'd0);
        tick();
        chk("tmo_err", 32'(fetch_err), 32'd1);
        chk("tmo_halted", 32'(halted), 32'd1);

        // Reset mid-fetch at pc 7.
        do_reset();
        serve(9'h021);
        accept(1, 1, 1, 8'd7, 0, 0);
        wait_req();
        chk("pc7_addr", 32'(imem_addr), 32'd7);
        tick();
        reset = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 9'h0AA;
        tick();
        reset = 1'b0;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_instr", 32'(instruction), 32'd0);
        tick();
        imem_valid = 1'b0;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_next", 32'(imem_addr), 32'd0);

        // Five fetches, two redirects.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            serve(9'(i));
            if (i < 4) begin
                if (i == 1) accept(1, 1, 1, 8'd20, 0, 0);
                else if (i == 3) accept(1, 1, 0, 0, 5'd2, 0);
                else accept(0, 0, 0, 0, 0, 0);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", 32'(fetch_count), 32'd5);
        chk("perf_redir", 32'(redirect_count), 32'd2);
`endif

        // Randomized run.
        hcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            hcnt = halted ? hcnt + 1 : 0;
            reset = (hcnt > 3) || ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 2) == 0);
            imem_valid = ($urandom_range(0, 2) == 0);
            imem_rdata = 9'($urandom);
            branch = $urandom_range(0, 1) == 1;
            takeit = $urandom_range(0, 1) == 1;
            direct_flag = $urandom_range(0, 1) == 1;
            branch_target = 8'($urandom);
            branch_offset = 5'($urandom);
            halt = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
